wb_commit_stage: RTL and testbench
==================================

// Module: wb_commit_stage
// PURPOSE
//  Parametrised write-back/commit stage; last pipeline stage after MEM. Registers the MEM bus,
//  writes the GPR file and drives the external CSR unit's write/exception/ertn ports.
//  Generates the flush for IF/ID/EX/MEM.
//  Over the previous WB: interrupts are merged in, exception causes are fully priority-encoded,
//  and CSR writes are suppressed on excepting instructions.
// PARAMETERS
//  DATA_W     32  datapath / PC / CSR width
//  CAUSE_W    17  exception-cause vector width (bits >=6 reserved)
//  CSR_NUM_W  14  CSR index width
//  RF_ADDR_W   5  GPR index width
//  MS_BUS_W   derived = 4*DATA_W+CSR_NUM_W+CAUSE_W+RF_ADDR_W+5 (169 at defaults)
// PORTS
//  clk               in   1          clock
//  reset             in   1          async, active-high
//  ms_to_ws_valid    in   1          MEM holds valid instr
//  ms_to_ws_bus      in   MS_BUS_W   {rdcntid,vaddr,ertn,csr_we,csr_rd,csr_wmask,csr_num,cause,gr_we,dest,result,pc} MSB->LSB
//  ws_allowin        out  1          stage can accept
//  ws_to_rf_bus      out  RF_ADDR_W+DATA_W+1  {we,waddr,wdata}
//  ws_csr            out  1          valid CSR rd/wr in WB (ID stalls on it)
//  ws_to_ds_dest     out  RF_ADDR_W  forward dest, 0 if no write
//  ws_to_ds_value    out  DATA_W     forward data, 0 if no write
//  ws_reflush_fs_bus out  DATA_W+1   {flush,target}
//  ws_reflush_ds/es/ms out 1 each    flush pulses
//  has_int           in   1          pending interrupt from CSR unit
//  csr_num/csr_we/csr_wmask/csr_wvalue out            CSR access; we gated (see below)
//  csr_rvalue        in   DATA_W     CSR read data (comb.)
//  ws_ex/ws_ertn     out  1          exception / ertn commit strobes
//  ws_ecode/ws_esubcode/ws_vaddr/ws_pc out 6/9/DATA_W/DATA_W   exception info to CSR
//  ex_entry/era_entry in  DATA_W     EENTRY / ERA
//  debug_wb_pc/rf_wen/rf_wnum/rf_wdata out DATA_W/(DATA_W/8)/RF_ADDR_W/DATA_W  trace
// BEHAVIOUR
//  - Reset: ws_valid=0, bus reg=0; hence all outputs 0 (allowin=1).
//  - ready_go=1; allowin=!ws_valid|ready_go. Bus reg loads on ms_to_ws_valid&allowin.
//  - ws_valid next: reset->0; flush->0 (overrides incoming, MEM killed same cycle);
//    else if allowin -> ms_to_ws_valid.
//  - Effective cause = bus cause | {has_int&ws_valid at bit0}; bits >=6 nonzero map to INE.
//  - Priority (first wins): INT(b0)>ADEF(b2,sub=ADEF)>INE(b5/reserved)>SYS(b1)>BRK(b4)>ALE(b3).
//    ecode/esubcode 0 when no cause.
//  - ws_ex = ws_valid & |cause; flush = ws_valid&(ws_ex|ertn); exception wins over ertn.
//    target = ex ? ex_entry : era_entry. All four flush outputs equal, combinational, one cycle.
//  - Excepting instr: rf_we=0, csr_we=0.
//    csr_we = ws_valid & bus_csr_we & !ws_ex; csr_wvalue = result.
//  - rf_we = ws_valid & gr_we & !ws_ex; wdata = (csr_rd|rdcntid) ? csr_rvalue : result.
//  - Forward outputs masked to 0 when !rf_we. debug_wb_rf_wen = {DATA_W/8{rf_we}}.
//  - Back-to-back: instr following flushing instr never sets ws_valid.
//    Reset mid-flush drops flush immediately.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: adds out ws_retire_cnt[63:0].
//    Increments by 1 each cycle ws_valid&!ws_ex (ertn counts); reset 0; wraps at 2^64-1 -> 0.
//  Undefined: port and counter absent; other behaviour identical.
// STRUCTURE
//  cpu_defs_pkg: ECODE_*/ESUBCODE_*, CSR_* numbers, cause bit indices CAUSE_INT..CAUSE_INE.
//  Sub-module wb_ex_prio: cause vector -> {ex,ecode,esubcode} (combinational).
// TESTING
//  1 ALU: gr_we=1,dest=5,result=0x1234 -> rf bus {1,5,0x1234}, fwd same, no flush.
//  2 cause=b1|b3 -> ecode 0xB, flush target=ex_entry, rf_we=0, next cycle ws_valid=0.
//  3 csrwr with has_int=1 -> ecode 0, csr_we=0, flush to ex_entry.
//  4 ertn, era_entry=0x1C000100 -> ws_ertn=1, flush bus {1,0x1C000100}.
//  5 csrrd num=0x5, csr_rvalue=0xA -> wdata 0xA, ws_csr=1.
//  6 reset asserted mid-stream -> all outputs 0 async; with WB_RETIRE_CNT_EN, counter=0 and
//    counts 3 after 3 clean retires.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: exception codes, CSR numbers, cause-vector bit
// positions and the decoded exception descriptor used by the commit stage.
package cpu_defs_pkg;

    // Exception codes reported to the CSR unit (ESTAT.Ecode)
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // Exception sub-codes (ESTAT.EsubCode)
    localparam logic [8:0] ESUBCODE_NONE = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    // CSR numbers touched by the exception / ertn path
    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_TID    = 14'h0040;

    // Bit positions inside the exception-cause vector; bits from
    // CAUSE_RSV_LO upward are reserved and treated as INE when set
    localparam int CAUSE_INT    = 0;
    localparam int CAUSE_SYS    = 1;
    localparam int CAUSE_ADEF   = 2;
    localparam int CAUSE_ALE    = 3;
    localparam int CAUSE_BRK    = 4;
    localparam int CAUSE_INE    = 5;
    localparam int CAUSE_RSV_LO = 6;

    // Winning exception after priority resolution
    typedef enum logic [2:0] {
        EX_NONE,
        EX_INT,
        EX_ADEF,
        EX_INE,
        EX_SYS,
        EX_BRK,
        EX_ALE
    } ex_kind_e;

    // Exception descriptor handed to the CSR unit
    typedef struct packed {
        logic       ex;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } ex_info_t;

    // Translate the winning exception into its ecode/esubcode pair
    function automatic ex_info_t exInfo(input ex_kind_e kind);
        ex_info_t info;
        info = '{ex: 1'b1, ecode: ECODE_INT, esubcode: ESUBCODE_NONE};
        case (kind)
            EX_INT:  info.ecode = ECODE_INT;
            EX_ADEF: begin
                info.ecode    = ECODE_ADE;
                info.esubcode = ESUBCODE_ADEF;
            end
            EX_INE:  info.ecode = ECODE_INE;
            EX_SYS:  info.ecode = ECODE_SYS;
            EX_BRK:  info.ecode = ECODE_BRK;
            EX_ALE:  info.ecode = ECODE_ALE;
            default: info = '{ex: 1'b0, ecode: 6'h00, esubcode: ESUBCODE_NONE};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/wb_ex_prio.sv
// Exception priority encoder for the commit stage.
// Order (first wins): INT > ADEF > INE (incl. reserved bits) > SYS > BRK > ALE.
// With no cause set, ex=0 and ecode/esubcode are 0.
module wb_ex_prio
    import cpu_defs_pkg::*;
#(
    parameter int CAUSE_W = 17
) (
    input  logic [CAUSE_W-1:0] i_cause,
    output logic               o_ex,
    output logic [5:0]         o_ecode,
    output logic [8:0]         o_esubcode
);

    logic     w_reserved;
    ex_kind_e w_kind;
    ex_info_t w_info;

    assign w_reserved = |(i_cause >> CAUSE_RSV_LO);

    // Pick the highest-priority pending exception
    always_comb begin
        w_kind = EX_NONE;
        if (i_cause[CAUSE_INT])
            w_kind = EX_INT;
        else if (i_cause[CAUSE_ADEF])
            w_kind = EX_ADEF;
        else if (i_cause[CAUSE_INE] | w_reserved)
            w_kind = EX_INE;
        else if (i_cause[CAUSE_SYS])
            w_kind = EX_SYS;
        else if (i_cause[CAUSE_BRK])
            w_kind = EX_BRK;
        else if (i_cause[CAUSE_ALE])
            w_kind = EX_ALE;
    end

    assign w_info     = exInfo(w_kind);
    assign o_ex       = w_info.ex;
    assign o_ecode    = w_info.ecode;
    assign o_esubcode = w_info.esubcode;

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: registers the MEM bus, writes the GPR file,
// drives the CSR unit (writes, exceptions, ertn) and flushes IF/ID/EX/MEM.
// Pending interrupts are merged into the cause vector; CSR and GPR writes are
// suppressed on excepting instructions.
// Optional: define WB_RETIRE_CNT_EN to add the 64-bit ws_retire_cnt output.
module wb_commit_stage
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CAUSE_W   = 17,
    parameter int CSR_NUM_W = 14,
    parameter int RF_ADDR_W = 5,
    parameter int MS_BUS_W  = 4*DATA_W + CSR_NUM_W + CAUSE_W + RF_ADDR_W + 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ms_to_ws_valid,
    input  logic [MS_BUS_W-1:0]         ms_to_ws_bus,
    output logic                        ws_allowin,
    output logic [RF_ADDR_W+DATA_W:0]   ws_to_rf_bus,
    output logic                        ws_csr,
    output logic [RF_ADDR_W-1:0]        ws_to_ds_dest,
    output logic [DATA_W-1:0]           ws_to_ds_value,
    output logic [DATA_W:0]             ws_reflush_fs_bus,
    output logic                        ws_reflush_ds,
    output logic                        ws_reflush_es,
    output logic                        ws_reflush_ms,
    input  logic                        has_int,
    output logic [CSR_NUM_W-1:0]        csr_num,
    output logic                        csr_we,
    output logic [DATA_W-1:0]           csr_wmask,
    output logic [DATA_W-1:0]           csr_wvalue,
    input  logic [DATA_W-1:0]           csr_rvalue,
    output logic                        ws_ex,
    output logic                        ws_ertn,
    output logic [5:0]                  ws_ecode,
    output logic [8:0]                  ws_esubcode,
    output logic [DATA_W-1:0]           ws_vaddr,
    output logic [DATA_W-1:0]           ws_pc,
    input  logic [DATA_W-1:0]           ex_entry,
    input  logic [DATA_W-1:0]           era_entry,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]                 ws_retire_cnt,
`endif
    output logic [DATA_W-1:0]           debug_wb_pc,
    output logic [DATA_W/8-1:0]         debug_wb_rf_wen,
    output logic [RF_ADDR_W-1:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]           debug_wb_rf_wdata
);

    logic                 r_valid;
    logic [MS_BUS_W-1:0]  r_bus;

    logic                 w_rdcntid;
    logic [DATA_W-1:0]    w_vaddr;
    logic                 w_ertn;
    logic                 w_csrWe;
    logic                 w_csrRd;
    logic [DATA_W-1:0]    w_csrWmask;
    logic [CSR_NUM_W-1:0] w_csrNum;
    logic [CAUSE_W-1:0]   w_busCause;
    logic                 w_grWe;
    logic [RF_ADDR_W-1:0] w_dest;
    logic [DATA_W-1:0]    w_result;
    logic [DATA_W-1:0]    w_pc;

    logic                 w_readyGo;
    logic [CAUSE_W-1:0]   w_cause;
    logic                 w_ex;
    logic [5:0]           w_ecode;
    logic [8:0]           w_esubcode;
    logic                 w_flush;
    logic                 w_rfWe;
    logic [DATA_W-1:0]    w_rfWdata;

    assign {w_rdcntid, w_vaddr, w_ertn, w_csrWe, w_csrRd, w_csrWmask, w_csrNum,
            w_busCause, w_grWe, w_dest, w_result, w_pc} = r_bus;

    assign w_readyGo  = 1'b1;
    assign ws_allowin = !r_valid | w_readyGo;

    // Interrupt rides on cause bit 0; an empty stage reports no cause at all
    assign w_cause = (w_busCause | {{(CAUSE_W-1){1'b0}}, has_int}) & {CAUSE_W{r_valid}};

    wb_ex_prio #(
        .CAUSE_W    (CAUSE_W)
    ) u_ex_prio (
        .i_cause    (w_cause),
        .o_ex       (w_ex),
        .o_ecode    (w_ecode),
        .o_esubcode (w_esubcode)
    );

    assign ws_ex       = w_ex;
    assign ws_ertn     = r_valid & w_ertn & !w_ex;
    assign ws_ecode    = w_ecode;
    assign ws_esubcode = w_esubcode;
    assign ws_vaddr    = w_vaddr;
    assign ws_pc       = w_pc;

    assign w_flush           = r_valid & (w_ex | w_ertn);
    assign ws_reflush_fs_bus = {w_flush, (w_ex ? ex_entry : era_entry) & {DATA_W{w_flush}}};
    assign ws_reflush_ds     = w_flush;
    assign ws_reflush_es     = w_flush;
    assign ws_reflush_ms     = w_flush;

    assign csr_num    = w_csrNum;
    assign csr_we     = r_valid & w_csrWe & !w_ex;
    assign csr_wmask  = w_csrWmask;
    assign csr_wvalue = w_result;
    assign ws_csr     = r_valid & (w_csrWe | w_csrRd);

    assign w_rfWe         = r_valid & w_grWe & !w_ex;
    assign w_rfWdata      = (w_csrRd | w_rdcntid) ? csr_rvalue : w_result;
    assign ws_to_rf_bus   = {w_rfWe, w_dest, w_rfWdata};
    assign ws_to_ds_dest  = w_rfWe ? w_dest : '0;
    assign ws_to_ds_value = w_rfWe ? w_rfWdata : '0;

    assign debug_wb_pc       = w_pc;
    assign debug_wb_rf_wen   = {(DATA_W/8){w_rfWe}};
    assign debug_wb_rf_wnum  = w_dest;
    assign debug_wb_rf_wdata = w_rfWdata;

    // Stage occupancy: a flush kills both this instruction and the one arriving from MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_valid <= 1'b0;
        else if (w_flush)
            r_valid <= 1'b0;
        else if (ws_allowin)
            r_valid <= ms_to_ws_valid;
    end

    // Capture the MEM bus whenever a valid instruction is handed over
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_bus <= '0;
        else if (ms_to_ws_valid & ws_allowin)
            r_bus <= ms_to_ws_bus;
    end

`ifdef WB_RETIRE_CNT_EN
    // Count retired instructions (ertn included, excepting ones excluded); wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ws_retire_cnt <= 64'd0;
        else if (r_valid & !w_ex)
            ws_retire_cnt <= ws_retire_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed testbench for wb_commit_stage: ALU write-back, exception priority,
// interrupt on CSR write, ertn, CSR read, flush kill of the following
// instruction and async reset. Checks the retire counter when
// WB_RETIRE_CNT_EN is defined.
module tb_wb_commit_stage;

    localparam int DATA_W    = 32;
    localparam int CAUSE_W   = 17;
    localparam int CSR_NUM_W = 14;
    localparam int RF_ADDR_W = 5;
    localparam int MS_BUS_W  = 4*DATA_W + CSR_NUM_W + CAUSE_W + RF_ADDR_W + 5;

    localparam logic [31:0] EX_ENTRY  = 32'h1C008000;
    localparam logic [31:0] ERA_ENTRY = 32'h1C000100;

    logic                        clk;
    logic                        reset;
    logic                        ms_to_ws_valid;
    logic [MS_BUS_W-1:0]         ms_to_ws_bus;
    logic                        ws_allowin;
    logic [RF_ADDR_W+DATA_W:0]   ws_to_rf_bus;
    logic                        ws_csr;
    logic [RF_ADDR_W-1:0]        ws_to_ds_dest;
    logic [DATA_W-1:0]           ws_to_ds_value;
    logic [DATA_W:0]             ws_reflush_fs_bus;
    logic                        ws_reflush_ds;
    logic                        ws_reflush_es;
    logic                        ws_reflush_ms;
    logic                        has_int;
    logic [CSR_NUM_W-1:0]        csr_num;
    logic                        csr_we;
    logic [DATA_W-1:0]           csr_wmask;
    logic [DATA_W-1:0]           csr_wvalue;
    logic [DATA_W-1:0]           csr_rvalue;
    logic                        ws_ex;
    logic                        ws_ertn;
    logic [5:0]                  ws_ecode;
    logic [8:0]                  ws_esubcode;
    logic [DATA_W-1:0]           ws_vaddr;
    logic [DATA_W-1:0]           ws_pc;
    logic [DATA_W-1:0]           ex_entry;
    logic [DATA_W-1:0]           era_entry;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]                 ws_retire_cnt;
`endif
    logic [DATA_W-1:0]           debug_wb_pc;
    logic [DATA_W/8-1:0]         debug_wb_rf_wen;
    logic [RF_ADDR_W-1:0]        debug_wb_rf_wnum;
    logic [DATA_W-1:0]           debug_wb_rf_wdata;

    int assertCount;
    int failCount;

    wb_commit_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_csr            (ws_csr),
        .ws_to_ds_dest     (ws_to_ds_dest),
        .ws_to_ds_value    (ws_to_ds_value),
        .ws_reflush_fs_bus (ws_reflush_fs_bus),
        .ws_reflush_ds     (ws_reflush_ds),
        .ws_reflush_es     (ws_reflush_es),
        .ws_reflush_ms     (ws_reflush_ms),
        .has_int           (has_int),
        .csr_num           (csr_num),
        .csr_we            (csr_we),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .csr_rvalue        (csr_rvalue),
        .ws_ex             (ws_ex),
        .ws_ertn           (ws_ertn),
        .ws_ecode          (ws_ecode),
        .ws_esubcode       (ws_esubcode),
        .ws_vaddr          (ws_vaddr),
        .ws_pc             (ws_pc),
        .ex_entry          (ex_entry),
        .era_entry         (era_entry),
`ifdef WB_RETIRE_CNT_EN
        .ws_retire_cnt     (ws_retire_cnt),
`endif
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack one MEM->WB bus word, MSB to LSB
    function automatic logic [MS_BUS_W-1:0] mkBus(
        input logic                 rdcntid,
        input logic [DATA_W-1:0]    vaddr,
        input logic                 ertn,
        input logic                 cWe,
        input logic                 cRd,
        input logic [DATA_W-1:0]    wmask,
        input logic [CSR_NUM_W-1:0] num,
        input logic [CAUSE_W-1:0]   cause,
        input logic                 grWe,
        input logic [RF_ADDR_W-1:0] dest,
        input logic [DATA_W-1:0]    result,
        input logic [DATA_W-1:0]    pc);
        return {rdcntid, vaddr, ertn, cWe, cRd, wmask, num, cause, grWe, dest, result, pc};
    endfunction

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one instruction from MEM for the next clock edge
    task automatic applyStimulus(input logic valid, input logic [MS_BUS_W-1:0] bus);
        ms_to_ws_valid = valid;
        ms_to_ws_bus   = bus;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [CAUSE_W-1:0] causeTab [6];
    logic [5:0]         ecodeTab [6];
    logic [8:0]         subTab   [6];

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        has_int     = 1'b0;
        csr_rvalue  = '0;
        ex_entry    = EX_ENTRY;
        era_entry   = ERA_ENTRY;
        applyStimulus(1'b0, '0);

        causeTab[0] = 17'h00024; ecodeTab[0] = 6'h08; subTab[0] = 9'h000;
        causeTab[1] = 17'h00022; ecodeTab[1] = 6'h0D; subTab[1] = 9'h000;
        causeTab[2] = 17'h00400; ecodeTab[2] = 6'h0D; subTab[2] = 9'h000;
        causeTab[3] = 17'h00018; ecodeTab[3] = 6'h0C; subTab[3] = 9'h000;
        causeTab[4] = 17'h00008; ecodeTab[4] = 6'h09; subTab[4] = 9'h000;
        causeTab[5] = 17'h00005; ecodeTab[5] = 6'h00; subTab[5] = 9'h000;

        // Reset state
        #3;
        checkOutput("rst_allowin", 64'(ws_allowin), 64'd1);
        checkOutput("rst_rfbus", 64'(ws_to_rf_bus), 64'd0);
        checkOutput("rst_flushbus", 64'(ws_reflush_fs_bus), 64'd0);
        checkOutput("rst_ex", 64'(ws_ex), 64'd0);
        checkOutput("rst_pc", 64'(debug_wb_pc), 64'd0);
        #4 reset = 1'b0;

        // 1: plain ALU write-back
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 32'h1C000000));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("alu_rfbus", 64'(ws_to_rf_bus), {26'd0, 1'b1, 5'd5, 32'h1234});
        checkOutput("alu_fwd_dest", 64'(ws_to_ds_dest), 64'd5);
        checkOutput("alu_fwd_val", 64'(ws_to_ds_value), 64'h1234);
        checkOutput("alu_flush", 64'(ws_reflush_fs_bus), 64'd0);
        checkOutput("alu_wen", 64'(debug_wb_rf_wen), 64'hF);
        checkOutput("alu_pc", 64'(debug_wb_pc), 64'h1C000000);

        // 2: SYS|ALE -> SYS wins; following instruction is killed
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 0, 0, 0, 17'h0000A, 1, 7, 32'h11, 32'h1C000004));
        tick();
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 32'h1C000008));
        checkOutput("sys_ex", 64'(ws_ex), 64'd1);
        checkOutput("sys_ecode", 64'(ws_ecode), 64'h0B);
        checkOutput("sys_flushbus", 64'(ws_reflush_fs_bus), {31'd0, 1'b1, EX_ENTRY});
        checkOutput("sys_flush_ds", 64'(ws_reflush_ds), 64'd1);
        checkOutput("sys_flush_ms", 64'(ws_reflush_ms), 64'd1);
        checkOutput("sys_rfwe", 64'(ws_to_rf_bus[37]), 64'd0);
        checkOutput("sys_fwd_dest", 64'(ws_to_ds_dest), 64'd0);
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("kill_wen", 64'(debug_wb_rf_wen), 64'd0);
        checkOutput("kill_fwd_dest", 64'(ws_to_ds_dest), 64'd0);
        checkOutput("kill_flush", 64'(ws_reflush_ds), 64'd0);

        // 3: csrwr while an interrupt is pending
        has_int = 1'b1;
        applyStimulus(1'b1, mkBus(0, 0, 0, 1, 0, 32'hFFFFFFFF, 14'h5, 0, 0, 0, 32'h55, 32'h1C00000C));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("int_ex", 64'(ws_ex), 64'd1);
        checkOutput("int_ecode", 64'(ws_ecode), 64'h00);
        checkOutput("int_csrwe", 64'(csr_we), 64'd0);
        checkOutput("int_flushbus", 64'(ws_reflush_fs_bus), {31'd0, 1'b1, EX_ENTRY});
        has_int = 1'b0;
        tick();

        // Clean csrwr commits its write
        applyStimulus(1'b1, mkBus(0, 0, 0, 1, 0, 32'h0000FFFF, 14'h6, 0, 0, 0, 32'h77, 32'h1C000010));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("csrwr_we", 64'(csr_we), 64'd1);
        checkOutput("csrwr_num", 64'(csr_num), 64'h6);
        checkOutput("csrwr_val", 64'(csr_wvalue), 64'h77);
        checkOutput("csrwr_mask", 64'(csr_wmask), 64'hFFFF);
        checkOutput("csrwr_wscsr", 64'(ws_csr), 64'd1);
        checkOutput("csrwr_ex", 64'(ws_ex), 64'd0);
        tick();

        // 4: ertn redirects to ERA
        applyStimulus(1'b1, mkBus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1C000014));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("ertn_strobe", 64'(ws_ertn), 64'd1);
        checkOutput("ertn_flushbus", 64'(ws_reflush_fs_bus), {31'd0, 1'b1, ERA_ENTRY});
        checkOutput("ertn_flush_es", 64'(ws_reflush_es), 64'd1);
        checkOutput("ertn_ex", 64'(ws_ex), 64'd0);
        tick();

        // Exception on an ertn: exception wins
        applyStimulus(1'b1, mkBus(0, 0, 1, 0, 0, 0, 0, 17'h00002, 0, 0, 0, 32'h1C000018));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("exertn_ertn", 64'(ws_ertn), 64'd0);
        checkOutput("exertn_flushbus", 64'(ws_reflush_fs_bus), {31'd0, 1'b1, EX_ENTRY});
        tick();

        // Priority table
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, mkBus(0, 32'hBAD0, 0, 0, 0, 0, 0, causeTab[i], 1, 1, 0, 32'h1C000020));
            tick();
            applyStimulus(1'b0, '0);
            checkOutput($sformatf("prio%0d_ecode", i), 64'(ws_ecode), 64'(ecodeTab[i]));
            checkOutput($sformatf("prio%0d_sub", i), 64'(ws_esubcode), 64'(subTab[i]));
            checkOutput($sformatf("prio%0d_ex", i), 64'(ws_ex), 64'd1);
            tick();
        end

        // 5: csrrd returns CSR read data into the GPR
        csr_rvalue = 32'hA;
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 1, 0, 14'h5, 0, 1, 3, 32'hDEAD, 32'h1C000024));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("csrrd_rfbus", 64'(ws_to_rf_bus), {26'd0, 1'b1, 5'd3, 32'hA});
        checkOutput("csrrd_wscsr", 64'(ws_csr), 64'd1);
        checkOutput("csrrd_fwd_val", 64'(ws_to_ds_value), 64'hA);
        checkOutput("csrrd_num", 64'(csr_num), 64'h5);
        checkOutput("csrrd_we", 64'(csr_we), 64'd0);
        tick();

        // rdcntid also takes the CSR read data
        csr_rvalue = 32'h99;
        applyStimulus(1'b1, mkBus(1, 0, 0, 0, 0, 0, 14'h40, 0, 1, 4, 32'h0, 32'h1C000028));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("rdcnt_wdata", 64'(debug_wb_rf_wdata), 64'h99);
        checkOutput("rdcnt_wscsr", 64'(ws_csr), 64'd0);
        tick();

        // 6: async reset mid-stream
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 32'h1C00002C));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("pre_rst_wen", 64'(debug_wb_rf_wen), 64'hF);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_rfbus", 64'(ws_to_rf_bus), 64'd0);
        checkOutput("arst_wen", 64'(debug_wb_rf_wen), 64'd0);
        checkOutput("arst_pc", 64'(debug_wb_pc), 64'd0);
        #2 reset = 1'b0;

        // Reset while a flush is being signalled
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 0, 0, 0, 17'h00002, 0, 0, 0, 32'h1C000030));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("preflush", 64'(ws_reflush_ds), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstflush_bus", 64'(ws_reflush_fs_bus), 64'd0);
        checkOutput("rstflush_ds", 64'(ws_reflush_ds), 64'd0);
        checkOutput("rstflush_ex", 64'(ws_ex), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("cnt_rst", ws_retire_cnt, 64'd0);
`endif
        #2 reset = 1'b0;

        // Three clean retires back to back
        applyStimulus(1'b1, mkBus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h1, 32'h1C000040));
        tick();
        tick();
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("stream_allowin", 64'(ws_allowin), 64'd1);
        tick();
        checkOutput("stream_idle_wen", 64'(debug_wb_rf_wen), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("cnt_three", ws_retire_cnt, 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
